shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Bit-serial shifter: one bit per cycle, IDLE/SHIFT/DONE sequencing.
// Define SHIFT_SEQUENCER_ROTATE_EN to enable ROL/ROR (else illegal).
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
`endif

  localparam logic [SHAMT_W-1:0] CNT_ONE = 1;

  logic [1:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               err_q, err_d;

  logic               accept;
  logic               op_legal;
  logic               fast;
  logic [WIDTH-1:0]   step;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_PASS,
      OP_SLL,
      OP_SRL,
      OP_SRA:  op_legal = 1'b1;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      OP_ROL,
      OP_ROR:  op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // Requests needing no shifting finish on the very next cycle.
  assign fast = (shamt == '0) || (op == OP_PASS) || !op_legal;

  assign accept = start &&
                  ((state_q == S_IDLE) || (state_q == S_DONE));

  // SRA reuses the current MSB, which stays equal to the original MSB.
  always_comb begin
    step = work_q;
    case (op_q)
      OP_SLL:  step = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      OP_ROL:  step = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      OP_ROR:  step = {work_q[0], work_q[WIDTH-1:1]};
`endif
      default: step = work_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE,
      S_DONE: begin
        if (accept) begin
          op_d   = op;
          work_d = data_in;
          cnt_d  = shamt;
          if (fast) begin
            state_d = S_DONE;
            err_d   = !op_legal;
            if (op_legal) begin
              result_d = data_in;
            end
          end else begin
            state_d = S_SHIFT;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d  = S_DONE;
          result_d = step;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      op_q     <= OP_PASS;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign result = result_q;

endmodule
